// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined RISC-V immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

endpackage

// File: rtl/imm_extract.sv
// Combinational decode of the instruction format and sign-extended immediate.
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          RV64_EN = 1'b0
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            target_vld
);

  logic [31:0] imm32;

  always_comb begin
    imm32      = '0;
    imm_type   = IMM_NONE;
    target_vld = 1'b0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm_type = IMM_I;
        imm32    = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP_IMM32: begin
        if (RV64_EN) begin
          imm_type = IMM_I;
          imm32    = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        imm_type   = IMM_B;
        target_vld = 1'b1;
        imm32      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI: begin
        imm_type = IMM_U;
        imm32    = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        imm_type   = IMM_U;
        target_vld = 1'b1;
        imm32      = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        imm_type   = IMM_J;
        target_vld = 1'b1;
        imm32      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    // Every format fits in 32 bits; widen to XLEN from bit 31 (covers U on RV64).
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator: S1 holds the decode, S2 adds the PC target.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          RV64_EN = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic            out_target_vld,
  output logic [XLEN-1:0] out_pc
);

  logic [XLEN-1:0] x_imm;
  imm_type_e       x_type;
  logic            x_tvld;

  imm_extract #(.XLEN(XLEN), .RV64_EN(RV64_EN)) u_extract (
    .instr      (in_instr),
    .imm        (x_imm),
    .imm_type   (x_type),
    .target_vld (x_tvld)
  );

  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s1_imm_q, s1_imm_d;
  imm_type_e       s1_type_q, s1_type_d;
  logic [XLEN-1:0] s1_pc_q, s1_pc_d;
  logic            s1_tvld_q, s1_tvld_d;

  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_imm_q, s2_imm_d;
  imm_type_e       s2_type_q, s2_type_d;
  logic [XLEN-1:0] s2_pc_q, s2_pc_d;
  logic [XLEN-1:0] s2_target_q, s2_target_d;
  logic            s2_tvld_q, s2_tvld_d;

  logic s2_adv, s1_adv;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = flush || s1_adv;

    s1_valid_d  = s1_valid_q;
    s1_imm_d    = s1_imm_q;
    s1_type_d   = s1_type_q;
    s1_pc_d     = s1_pc_q;
    s1_tvld_d   = s1_tvld_q;
    s2_valid_d  = s2_valid_q;
    s2_imm_d    = s2_imm_q;
    s2_type_d   = s2_type_q;
    s2_pc_d     = s2_pc_q;
    s2_target_d = s2_target_q;
    s2_tvld_d   = s2_tvld_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_imm_d    = s1_imm_q;
          s2_type_d   = s1_type_q;
          s2_pc_d     = s1_pc_q;
          s2_target_d = s1_pc_q + s1_imm_q;
          s2_tvld_d   = s1_tvld_q;
        end
      end
      if (s1_adv) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_imm_d  = x_imm;
          s1_type_d = x_type;
          s1_pc_d   = in_pc;
          s1_tvld_d = x_tvld;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_imm_q    <= s1_imm_d;
    s1_type_q   <= s1_type_d;
    s1_pc_q     <= s1_pc_d;
    s1_tvld_q   <= s1_tvld_d;
    s2_imm_q    <= s2_imm_d;
    s2_type_q   <= s2_type_d;
    s2_pc_q     <= s2_pc_d;
    s2_target_q <= s2_target_d;
    s2_tvld_q   <= s2_tvld_d;
  end

  // Data flops carry no reset, so outputs are masked to zero whenever S2 is empty.
  always_comb begin
    out_valid      = s2_valid_q;
    out_imm        = s2_valid_q ? s2_imm_q    : '0;
    out_type       = s2_valid_q ? s2_type_q   : IMM_NONE;
    out_target     = s2_valid_q ? s2_target_q : '0;
    out_target_vld = s2_valid_q && s2_tvld_q;
    out_pc         = s2_valid_q ? s2_pc_q     : '0;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64/RV64 instances driven in lockstep.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        o32_in_ready, o32_valid, o32_tvld;
  logic [31:0] o32_imm, o32_target, o32_pc;
  logic [2:0]  o32_type;
  logic        o64_in_ready, o64_valid, o64_tvld;
  logic [63:0] o64_imm, o64_target, o64_pc;
  logic [2:0]  o64_type;

  imm_gen_pipe #(.XLEN(32), .RV64_EN(1'b0)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o32_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(o32_valid), .out_ready(out_ready), .out_imm(o32_imm), .out_type(o32_type),
    .out_target(o32_target), .out_target_vld(o32_tvld), .out_pc(o32_pc)
  );

  imm_gen_pipe #(.XLEN(64), .RV64_EN(1'b1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o64_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(o64_valid), .out_ready(out_ready), .out_imm(o64_imm), .out_type(o64_type),
    .out_target(o64_target), .out_target_vld(o64_tvld), .out_pc(o64_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_out = 0;
  int n_lost = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    bit          vis;
  } ent_t;
  ent_t q[$];

  logic [6:0] opc_tbl [11] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011, 7'b0100011,
                               7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111,
                               7'b0110011};

  function automatic longint sext(input longint v, input int nb);
    longint half;
    half = longint'(1) << (nb - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  // Reference decode straight from the ISA field definitions, in 64-bit arithmetic.
  function automatic void ref_model(input logic [31:0] ins, input bit rv64,
                                    output logic [63:0] imm, output logic [2:0] ty,
                                    output bit tv);
    longint w;
    w   = longint'(ins);
    imm = '0;
    ty  = 3'd0;
    tv  = 1'b0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        ty = 3'd1; imm = sext((w >> 20) & 'hFFF, 12);
      end
      7'b0011011: if (rv64) begin
        ty = 3'd1; imm = sext((w >> 20) & 'hFFF, 12);
      end
      7'b0100011: begin
        ty = 3'd2; imm = sext((((w >> 25) & 'h7F) << 5) | ((w >> 7) & 'h1F), 12);
      end
      7'b1100011: begin
        ty = 3'd3; tv = 1'b1;
        imm = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                   (((w >> 25) & 'h3F) << 5) | (((w >> 8) & 'hF) << 1), 13);
      end
      7'b0110111: begin
        ty = 3'd4; imm = sext(w & 'hFFFFF000, 32);
      end
      7'b0010111: begin
        ty = 3'd4; tv = 1'b1; imm = sext(w & 'hFFFFF000, 32);
      end
      7'b1101111: begin
        ty = 3'd5; tv = 1'b1;
        imm = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 'hFF) << 12) |
                   (((w >> 20) & 1) << 11) | (((w >> 21) & 'h3FF) << 1), 21);
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs();
    logic [63:0] ei32, ei64, epc;
    logic [2:0]  t32, t64;
    bit          tv32, tv64, ev;
    logic [31:0] e32, p32;
    ev = (q.size() > 0) && q[0].vis;
    ei32 = '0; ei64 = '0; t32 = '0; t64 = '0; tv32 = 0; tv64 = 0; epc = '0;
    if (ev) begin
      ref_model(q[0].instr, 1'b0, ei32, t32, tv32);
      ref_model(q[0].instr, 1'b1, ei64, t64, tv64);
      epc = q[0].pc;
    end
    e32 = ei32[31:0];
    p32 = epc[31:0];
    check("out_valid32", {63'b0, o32_valid}, {63'b0, ev});
    check("out_imm32", {32'b0, o32_imm}, {32'b0, e32});
    check("out_type32", {61'b0, o32_type}, {61'b0, t32});
    check("out_target32", {32'b0, o32_target}, ev ? {32'b0, p32 + e32} : 64'b0);
    check("out_tvld32", {63'b0, o32_tvld}, {63'b0, tv32});
    check("out_pc32", {32'b0, o32_pc}, {32'b0, p32});
    check("out_valid64", {63'b0, o64_valid}, {63'b0, ev});
    check("out_imm64", o64_imm, ei64);
    check("out_type64", {61'b0, o64_type}, {61'b0, t64});
    check("out_target64", o64_target, ev ? epc + ei64 : 64'b0);
    check("out_tvld64", {63'b0, o64_tvld}, {63'b0, tv64});
    check("out_pc64", o64_pc, epc);
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                     input bit ordy, input bit fl);
    bit exp_rdy, acc;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = fl || (q.size() < 2) || ordy;
    check("in_ready32", {63'b0, o32_in_ready}, {63'b0, exp_rdy});
    check("in_ready64", {63'b0, o64_in_ready}, {63'b0, exp_rdy});
    acc = v && exp_rdy && !fl;
    if (o32_valid && ordy && !fl) n_out++;
    @(posedge clk);
    if (fl) begin
      n_lost += q.size();
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].vis && ordy) void'(q.pop_front());
      if (q.size() > 0 && !q[0].vis) q[0].vis = 1'b1;
    end
    if (acc) begin
      q.push_back('{instr: ins, pc: pc, vis: 1'b0});
      n_acc++;
    end
    #1;
    chk_outputs();
  endtask

  task automatic rst_pulse();
    #1 rst_n = 1'b0;
    #1;
    n_lost += q.size();
    q.delete();
    chk_outputs();
    check("rst_in_ready", {63'b0, o32_in_ready}, 64'd1);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [63:0] rpc;
    #3;
    chk_outputs();
    #9 rst_n = 1'b1;
    #1;
    chk_outputs();
    check("post_reset_in_ready", {63'b0, o32_in_ready}, 64'd1);

    // BEQ backward: result two cycles after acceptance
    cyc(1, 32'hFE000EE3, 64'h100, 1, 0);
    check("beq_not_yet", {63'b0, o32_valid}, 64'd0);
    cyc(0, 32'h0, 64'h0, 1, 0);
    check("beq_valid", {63'b0, o32_valid}, 64'd1);
    check("beq_imm", {32'b0, o32_imm}, 64'hFFFFFFFC);
    check("beq_type", {61'b0, o32_type}, 64'd3);
    check("beq_target", {32'b0, o32_target}, 64'hFC);
    check("beq_tvld", {63'b0, o32_tvld}, 64'd1);

    // JAL forward and wrapping target
    cyc(1, 32'h001000EF, 64'h1000, 1, 0);
    cyc(1, 32'h001000EF, 64'hFFFFF800, 1, 0);
    check("jal_imm", {32'b0, o32_imm}, 64'h800);
    check("jal_type", {61'b0, o32_type}, 64'd5);
    check("jal_target", {32'b0, o32_target}, 64'h1800);
    cyc(0, 32'h0, 64'h0, 1, 0);
    check("jal_wrap_target", {32'b0, o32_target}, 64'h0);

    // LUI sign extension on both widths
    cyc(1, 32'hABCDE2B7, 64'h40, 1, 0);
    cyc(0, 32'h0, 64'h0, 1, 0);
    check("lui_imm32", {32'b0, o32_imm}, 64'hABCDE000);
    check("lui_imm64", o64_imm, 64'hFFFFFFFFABCDE000);
    check("lui_tvld", {63'b0, o32_tvld}, 64'd0);

    // Store -1 and an unknown opcode
    cyc(1, 32'hFE002FA3, 64'h0, 1, 0);
    cyc(1, 32'h0000007F, 64'h8, 1, 0);
    check("sw_imm", {32'b0, o32_imm}, 64'hFFFFFFFF);
    check("sw_type", {61'b0, o32_type}, 64'd2);
    cyc(0, 32'h0, 64'h0, 1, 0);
    check("unk_type", {61'b0, o32_type}, 64'd0);
    check("unk_imm", {32'b0, o32_imm}, 64'd0);
    cyc(0, 32'h0, 64'h0, 1, 0);

    // Backpressure: two held, third refused until the consumer drains
    cyc(1, 32'h00500093, 64'h200, 0, 0);
    cyc(1, 32'h0080006F, 64'h204, 0, 0);
    cyc(1, 32'hFFF10113, 64'h208, 0, 0);
    check("bp_third_refused", {63'b0, o32_in_ready}, 64'd0);
    cyc(1, 32'hFFF10113, 64'h208, 0, 0);
    cyc(1, 32'hFFF10113, 64'h208, 0, 0);
    cyc(1, 32'hFFF10113, 64'h208, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 64'h0, 1, 0);

    // Flush with both stages full and an input pending
    cyc(1, 32'h00000463, 64'h300, 0, 0);
    cyc(1, 32'h00000517, 64'h304, 0, 0);
    cyc(1, 32'h123450B7, 64'h308, 0, 1);
    check("flush_out_valid", {63'b0, o32_valid}, 64'd0);
    for (int i = 0; i < 3; i++) cyc(0, 32'h0, 64'h0, 1, 0);

    // Asynchronous reset mid-stream
    cyc(1, 32'h00A00513, 64'h400, 1, 0);
    cyc(1, 32'h00B00593, 64'h404, 1, 0);
    rst_pulse();
    cyc(0, 32'h0, 64'h0, 1, 0);

    // Randomised traffic with random backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      r[6:0] = opc_tbl[$urandom_range(0, 10)];
      rpc = {32'($urandom), 32'($urandom)};
      cyc(($urandom_range(0, 3) != 0), r, rpc, ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 64'h0, 1, 0);
    check("drain_count", 64'(n_out), 64'(n_acc - n_lost));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
